// File: rtl/seq_bit_player_if.sv
// seq_bit_player_if: control, pattern-RAM read port and serial output bundle of seq_bit_player (optional PAUSE with SEQ_BIT_PLAYER_PAUSE_EN)
interface seq_bit_player_if #(
  parameter int ADDRWIDTH = 14,
  parameter int REPWIDTH = 8
);
  logic start;
  logic stop;
  logic [ADDRWIDTH-1:0] conf_start_addr;
  logic [ADDRWIDTH:0] conf_size;
  logic [REPWIDTH-1:0] conf_repeat;
  logic [ADDRWIDTH-1:0] ram_addr;
  logic ram_en;
  logic ram_do;
  logic seq_out;
  logic seq_valid;
  logic busy;
  logic done;
`ifdef SEQ_BIT_PLAYER_PAUSE_EN
  logic pause;
  modport slave(
    input start, stop, conf_start_addr, conf_size, conf_repeat, ram_do, pause,
    output ram_addr, ram_en, seq_out, seq_valid, busy, done
  );
  modport master(
    output start, stop, conf_start_addr, conf_size, conf_repeat, ram_do, pause,
    input ram_addr, ram_en, seq_out, seq_valid, busy, done
  );
`else
  modport slave(
    input start, stop, conf_start_addr, conf_size, conf_repeat, ram_do,
    output ram_addr, ram_en, seq_out, seq_valid, busy, done
  );
  modport master(
    output start, stop, conf_start_addr, conf_size, conf_repeat, ram_do,
    input ram_addr, ram_en, seq_out, seq_valid, busy, done
  );
`endif
endinterface

// File: rtl/seq_bit_player.sv
// seq_bit_player: plays a bit range of a 1-bit pattern RAM as a qualified serial stream (optional PAUSE with SEQ_BIT_PLAYER_PAUSE_EN)
module seq_bit_player #(
  parameter int ADDRWIDTH = 14,
  parameter int REPWIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  seq_bit_player_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_n;
  logic [ADDRWIDTH-1:0] addr, addr_n, start_l, start_l_n;
  logic [ADDRWIDTH:0] bit_cnt, bit_n, size_l, size_l_n;
  logic [REPWIDTH-1:0] rep_cnt, rep_n, rep_l, rep_l_n;
  logic en, en_n, valid, valid_n, busy, busy_n, done, done_n;
  logic paused;
`ifdef SEQ_BIT_PLAYER_PAUSE_EN
  assign paused = bus.pause;
`else
  assign paused = 1'b0;
`endif
  assign bus.ram_addr = addr;
  assign bus.ram_en = en;
  assign bus.seq_out = bus.ram_do;
  assign bus.seq_valid = valid;
  assign bus.busy = busy;
  assign bus.done = done;
  // next-state: one address issued per RUN cycle, pass reload without gap, STOP aborts from any active state
  always_comb begin
    state_n = state;
    addr_n = addr;
    start_l_n = start_l;
    size_l_n = size_l;
    rep_l_n = rep_l;
    bit_n = bit_cnt;
    rep_n = rep_cnt;
    en_n = en;
    busy_n = busy;
    done_n = 1'b0;
    valid_n = en & ~bus.stop;
    if (state == IDLE) begin
      if (bus.start && !bus.stop && bus.conf_size != '0) begin
        start_l_n = bus.conf_start_addr;
        size_l_n = bus.conf_size;
        rep_l_n = bus.conf_repeat;
        addr_n = bus.conf_start_addr;
        bit_n = (ADDRWIDTH+1)'(1);
        rep_n = REPWIDTH'(1);
        en_n = 1'b1;
        busy_n = 1'b1;
        state_n = RUN;
      end
    end else if (bus.stop) begin
      en_n = 1'b0;
      busy_n = 1'b0;
      state_n = IDLE;
    end else if (state == FLUSH) begin
      done_n = 1'b1;
      busy_n = 1'b0;
      state_n = IDLE;
    end else if (paused) begin
      en_n = 1'b0;
    end else if (bit_cnt == size_l) begin
      if (rep_l != '0 && rep_cnt == rep_l) begin
        en_n = 1'b0;
        state_n = FLUSH;
      end else begin
        addr_n = start_l;
        bit_n = (ADDRWIDTH+1)'(1);
        rep_n = &rep_cnt ? rep_cnt : rep_cnt + REPWIDTH'(1);
        en_n = 1'b1;
      end
    end else begin
      addr_n = addr + ADDRWIDTH'(1);
      bit_n = bit_cnt + (ADDRWIDTH+1)'(1);
      en_n = 1'b1;
    end
  end
  // state and registered outputs, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      start_l <= '0;
      size_l <= '0;
      rep_l <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
      en <= 1'b0;
      valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      start_l <= start_l_n;
      size_l <= size_l_n;
      rep_l <= rep_l_n;
      bit_cnt <= bit_n;
      rep_cnt <= rep_n;
      en <= en_n;
      valid <= valid_n;
      busy <= busy_n;
      done <= done_n;
    end
  end
endmodule
